adc_frame_packer: RTL and testbench

//   Sits between the ADC capture path (adc_ctrl sample stream) and uart_tx byte input.

---
 rtl/adc_frame_packer.sv | 159 +++++++++++++++
 tb/tb_adc_frame_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// -----------------------------------------------------------------------------
// adc_frame_packer
//   Collects ADC sample bytes into a frame buffer. When the frame fills, or the
//   caller flushes a partial frame, it sends the frame as a byte stream:
//     SYNC0, SYNC1, seq, count, sample[0..count-1], csum
//   csum = (seq + count + sum of samples) mod 256.
//   seq increments after each completed frame. A host uses seq to detect lost
//   frames and csum to detect corrupt ones.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   s_data   in   [7:0] ADC sample byte
//   s_valid  in   s_data valid
//   s_ready  out  sample accepted this cycle when s_valid=1
//   flush    in   pulse: close the current partial frame
//   m_data   out  [7:0] byte to the UART transmitter
//   m_valid  out  m_data valid
//   m_ready  in   UART transmitter accepts m_data this cycle
//   busy     out  a frame is being transmitted
//   ovf      out  sticky: a sample was offered while s_ready=0
// -----------------------------------------------------------------------------
module adc_frame_packer #(
    parameter int         FRAME_LEN = 16,
    parameter logic [7:0] SYNC0     = 8'hA5,
    parameter logic [7:0] SYNC1     = 8'h5A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       flush,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       busy,
    output logic       ovf
);

    localparam int         IDX_W       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

    localparam logic [2:0] FILL = 3'd0;
    localparam logic [2:0] HDR0 = 3'd1;
    localparam logic [2:0] HDR1 = 3'd2;
    localparam logic [2:0] SEQ  = 3'd3;
    localparam logic [2:0] LEN  = 3'd4;
    localparam logic [2:0] DATA = 3'd5;
    localparam logic [2:0] CSUM = 3'd6;

    logic [2:0] state;
    logic [7:0] count;
    logic [7:0] seq;
    logic [7:0] idx;
    logic [7:0] acc;
    logic [7:0] frame_buf [FRAME_LEN];

    logic       accept;
    logic       close;
    logic       xfer;
    logic [7:0] count_inc;
    logic [7:0] sample_sum;
    logic [7:0] idx_nxt;

    assign s_ready = (state == FILL) && (count < FRAME_LEN_B);
    assign busy    = (state != FILL);
    assign accept  = s_valid && s_ready;
    assign xfer    = m_valid && m_ready;
    assign idx_nxt = idx + 8'd1;

    always_comb begin
        count_inc  = count + {7'd0, accept};
        sample_sum = acc + (accept ? s_data : 8'd0);
        // A flush only closes a frame that would contain at least one sample.
        close      = (state == FILL) &&
                     ((accept && (count_inc == FRAME_LEN_B)) ||
                      (flush && ((count != 8'd0) || accept)));
    end

    // Sample storage carries no reset: stale contents are never transmitted
    // because count is cleared by reset and at frame completion.
    always_ff @(posedge clk) begin
        if (accept)
            frame_buf[count[IDX_W-1:0]] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FILL;
            count   <= 8'd0;
            seq     <= 8'd0;
            idx     <= 8'd0;
            acc     <= 8'd0;
            m_valid <= 1'b0;
            m_data  <= 8'd0;
            ovf     <= 1'b0;
        end else begin
            if (s_valid && !s_ready)
                ovf <= 1'b1;

            case (state)
                FILL: begin
                    if (accept) begin
                        count <= count_inc;
                        acc   <= sample_sum;
                    end
                    if (close) begin
                        // Seed the checksum with the header fields it covers.
                        acc     <= sample_sum + seq + count_inc;
                        state   <= HDR0;
                        m_valid <= 1'b1;
                        m_data  <= SYNC0;
                    end
                end
                HDR0: if (xfer) begin
                    state  <= HDR1;
                    m_data <= SYNC1;
                end
                HDR1: if (xfer) begin
                    state  <= SEQ;
                    m_data <= seq;
                end
                SEQ: if (xfer) begin
                    state  <= LEN;
                    m_data <= count;
                end
                LEN: if (xfer) begin
                    // count >= 1 here: empty frames are never started.
                    state  <= DATA;
                    idx    <= 8'd0;
                    m_data <= frame_buf[0];
                end
                DATA: if (xfer) begin
                    if (idx == count - 8'd1) begin
                        state  <= CSUM;
                        m_data <= acc;
                    end else begin
                        idx    <= idx_nxt;
                        m_data <= frame_buf[idx_nxt[IDX_W-1:0]];
                    end
                end
                CSUM: if (xfer) begin
                    state   <= FILL;
                    m_valid <= 1'b0;
                    m_data  <= 8'd0;
                    count   <= 8'd0;
                    acc     <= 8'd0;
                    seq     <= seq + 8'd1;
                end
                default: begin
                    state   <= FILL;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
module tb_adc_frame_packer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       flush = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    logic [7:0] expq [$];

    adc_frame_packer #(.FRAME_LEN(4), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .flush   (flush),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fl);
        s_valid = 1'b1;
        s_data  = d;
        flush   = fl;
        tick();
        s_valid = 1'b0;
        flush   = 1'b0;
    endtask

    // Receive the first n bytes of expq, optionally with random back-pressure,
    // and check that stalled bytes stay put.
    task automatic recv(input int n, input bit rnd, input string tag);
        int k = 0;
        int cyc = 0;
        logic [7:0] d_prev;
        bit stall;
        while (k < n && cyc < 400) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stall   = m_valid && !m_ready;
            d_prev  = m_data;
            if (m_valid && m_ready) begin
                chk($sformatf("%s byte%0d", tag, k), {24'd0, m_data}, {24'd0, expq[k]});
                k++;
            end
            tick();
            if (stall) begin
                chk($sformatf("%s hold_data", tag), {24'd0, m_data}, {24'd0, d_prev});
                chk($sformatf("%s hold_valid", tag), {31'd0, m_valid}, 32'd1);
            end
            cyc++;
        end
        m_ready = 1'b0;
        chk($sformatf("%s bytes_received", tag), k, n);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " m_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, " busy"},    {31'd0, busy},    32'd0);
        chk({tag, " s_ready"}, {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] smp;

        // 1: reset held three cycles
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst m_data",  {24'd0, m_data},  32'd0);
        chk("rst busy",    {31'd0, busy},    32'd0);
        chk("rst ovf",     {31'd0, ovf},     32'd0);
        chk("rst s_ready", {31'd0, s_ready}, 32'd1);

        // 2: full frame, no back-pressure
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        chk("t2 not_yet", {31'd0, m_valid}, 32'd0);
        send_byte(8'h04, 1'b0);
        chk("t2 lat m_valid", {31'd0, m_valid}, 32'd1);
        chk("t2 lat m_data",  {24'd0, m_data},  32'hA5);
        chk("t2 s_ready_low", {31'd0, s_ready}, 32'd0);
        expq = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
        recv(9, 1'b0, "t2");
        chk_idle("t2 end");

        // 3: same frame after reset, with random back-pressure
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        recv(9, 1'b1, "t3");
        chk_idle("t3 end");

        // 4: partial frame closed by flush, seq=1
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4 lat m_data", {24'd0, m_data}, 32'hA5);
        expq = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        recv(7, 1'b1, "t4");
        chk_idle("t4 end");

        // flush on an empty frame is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_flush m_valid", {31'd0, m_valid}, 32'd0);
        chk("empty_flush busy",    {31'd0, busy},    32'd0);
        tick();
        chk("empty_flush still_idle", {31'd0, m_valid}, 32'd0);

        // flush with a same-cycle sample: one-sample frame, seq=2
        send_byte(8'h77, 1'b1);
        chk("fa lat m_data", {24'd0, m_data}, 32'hA5);
        expq = '{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h77, 8'h7A};
        recv(6, 1'b0, "fa");
        chk_idle("fa end");

        // 5: samples offered while sending, seq=3
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        chk("t5 s_ready", {31'd0, s_ready}, 32'd0);
        tick();
        chk("t5 ovf_set", {31'd0, ovf}, 32'd1);
        tick();
        s_valid = 1'b0;
        expq = '{8'hA5, 8'h5A, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h21};
        recv(9, 1'b1, "t5");
        chk_idle("t5 end");
        chk("t5 ovf_sticky", {31'd0, ovf}, 32'd1);

        // 6: 257 frames from a fresh reset, seq 00..FF then 00
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 ovf_cleared", {31'd0, ovf}, 32'd0);
        for (int f = 0; f < 257; f++) begin
            sum = 8'(f) + 8'd4;
            expq = '{8'hA5, 8'h5A, 8'(f), 8'h04};
            for (int j = 0; j < 4; j++) begin
                smp = 8'(f * 3 + j * 17);
                sum = sum + smp;
                expq.push_back(smp);
                send_byte(smp, 1'b0);
            end
            expq.push_back(sum);
            recv(9, f[0], $sformatf("t6 f%0d", f));
        end
        chk_idle("t6 end");

        // reset during DATA aborts the frame and restarts seq
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        expq = '{8'hA5, 8'h5A, 8'h01, 8'h04, 8'h11};
        recv(5, 1'b0, "t6 abort");
        chk("t6 in_data busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 abort m_valid", {31'd0, m_valid}, 32'd0);
        chk("t6 abort m_data",  {24'd0, m_data},  32'd0);
        chk("t6 abort busy",    {31'd0, busy},    32'd0);
        chk("t6 abort s_ready", {31'd0, s_ready}, 32'd1);
        send_byte(8'h09, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h06, 1'b0);
        expq = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h09, 8'h08, 8'h07, 8'h06, 8'h22};
        recv(9, 1'b1, "t6 after");
        chk_idle("t6 after end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
